// File: rtl/rotary_pkg.sv
// rtl/rotary_pkg.sv - shared types and flag indices for the rotary controller
package rotary_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    UPDATE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam int F_ROTL = 0;
  localparam int F_ROTR = 1;
  localparam int F_PUSH = 2;

  typedef logic [2:0] flags_t;

endpackage

// File: rtl/rotary_step_alu.sv
// rtl/rotary_step_alu.sv - bounded add/subtract of one step with saturate or wrap
module rotary_step_alu #(
  parameter int WIDTH = 8,
  parameter int MIN   = 0,
  parameter int MAX   = 255
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  input  logic [WIDTH:0]   mag,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] next,
  output logic             limit
);

  // Two extra bits: one for the carry above MAX, one for the sign below MIN.
  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] LO_S  = SW'(MIN);
  localparam logic signed [SW-1:0] HI_S  = SW'(MAX);
  localparam logic signed [SW-1:0] ONE_S = SW'(1);

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] res;
  logic [1:0]           unused_hi;

  // Signed sum, then clamp or fold back into [MIN, MAX]; exact landing on a bound is not a limit.
  always_comb begin
    delta = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    sum   = $signed({2'b00, value}) + delta;
    res   = sum;
    limit = 1'b0;
    if (sum > HI_S) begin
      limit = 1'b1;
      res   = wrap_en ? (LO_S + (sum - HI_S - ONE_S)) : HI_S;
    end else if (sum < LO_S) begin
      limit = 1'b1;
      res   = wrap_en ? (HI_S - (LO_S - sum - ONE_S)) : LO_S;
    end
    {unused_hi, next} = res;
  end

endmodule

// File: rtl/rotary_ctrl.sv
// rtl/rotary_ctrl.sv - polls/acks rotary decoder flags and presents bounded position events
module rotary_ctrl
  import rotary_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MIN       = 0,
  parameter int MAX       = 255,
  parameter int STEP      = 1,
  parameter int COARSE    = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             rotl_evt,
  input  logic             rotr_evt,
  input  logic             push_evt,
  output logic             read,
  input  logic             wrap_en,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [2:0]       evt_flags,
  output logic             evt_limit,
  output logic [WIDTH-1:0] value,
  output logic             mode
);

  // Step sizes carried at WIDTH+1 bits so a full-range coarse step still fits.
  localparam logic [WIDTH:0] STEP_V   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] COARSE_V = (WIDTH+1)'(COARSE);

  state_t         state, state_nxt;
  flags_t         cap;
  logic           any_evt;
  logic           cap_ld;
  logic           upd;
  logic           read_nxt;
  logic           valid_nxt;
  logic           step_neg;
  logic [WIDTH:0] step_mag;
  logic [WIDTH-1:0] alu_next;
  logic           alu_limit;

  assign any_evt = rotl_evt | rotr_evt | push_evt;

  // Opposite rotations cancel, so only a lone direction produces a step.
  assign step_neg = cap[F_ROTL];
  assign step_mag = (cap[F_ROTL] ^ cap[F_ROTR]) ? (mode ? COARSE_V : STEP_V) : '0;

  rotary_step_alu #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX)
  ) u_alu (
    .value   (value),
    .neg     (step_neg),
    .mag     (step_mag),
    .wrap_en (wrap_en),
    .next    (alu_next),
    .limit   (alu_limit)
  );

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; decoder flags are only looked at from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_evt) state_nxt = READ;
      READ:    state_nxt = UPDATE;
      UPDATE:  state_nxt = PRESENT;
      PRESENT: if (evt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: register enables and next values of the registered outputs.
  always_comb begin
    cap_ld    = (state == IDLE) && any_evt;
    upd       = (state == UPDATE);
    read_nxt  = (state_nxt == READ);
    valid_nxt = (state_nxt == PRESENT);
  end

  // Capture, position and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      read      <= 1'b0;
      evt_valid <= 1'b0;
      evt_flags <= '0;
      evt_limit <= 1'b0;
      value     <= WIDTH'(RESET_VAL);
      mode      <= 1'b0;
      cap       <= '0;
    end else begin
      read      <= read_nxt;
      evt_valid <= valid_nxt;
      if (cap_ld) begin
        cap[F_ROTL] <= rotl_evt;
        cap[F_ROTR] <= rotr_evt;
        cap[F_PUSH] <= push_evt;
      end
      if (upd) begin
        value     <= alu_next;
        evt_flags <= cap;
        evt_limit <= alu_limit;
        if (cap[F_PUSH]) mode <= ~mode;
      end
    end
  end

endmodule

// File: tb/tb_rotary_ctrl.sv
// tb/tb_rotary_ctrl.sv - directed self-checking bench for rotary_ctrl
module tb_rotary_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       wrap_en = 1'b0;
  logic       evt_ready = 1'b1;
  logic       read;
  logic       evt_valid;
  logic [2:0] evt_flags;
  logic       evt_limit;
  logic [7:0] value;
  logic       mode;

  // Decoder stand-in: set pulses latch flags, the edge ending a read pulse clears them.
  logic set_l = 1'b0, set_r = 1'b0, set_p = 1'b0;
  logic dl = 1'b0, dr = 1'b0, dp = 1'b0;

  int errors = 0;
  int checks = 0;
  int read_cnt = 0;
  int rc0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dl <= (read ? 1'b0 : dl) | set_l;
    dr <= (read ? 1'b0 : dr) | set_r;
    dp <= (read ? 1'b0 : dp) | set_p;
  end

  always @(posedge clk) if (read) read_cnt <= read_cnt + 1;

  rotary_ctrl #(
    .WIDTH     (8),
    .MIN       (0),
    .MAX       (9),
    .STEP      (1),
    .COARSE    (3),
    .RESET_VAL (0)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .rotl_evt  (dl),
    .rotr_evt  (dr),
    .push_evt  (dp),
    .read      (read),
    .wrap_en   (wrap_en),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_flags (evt_flags),
    .evt_limit (evt_limit),
    .value     (value),
    .mode      (mode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic post(input logic [2:0] f);
    {set_p, set_r, set_l} = f;
    @(negedge clk);
    {set_p, set_r, set_l} = 3'b000;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!evt_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_wait"}, 32'(evt_valid), 1);
  endtask

  task automatic do_evt(input string tag, input logic [2:0] f, input int ev,
                        input int el, input int em);
    int r0 = read_cnt;
    post(f);
    wait_valid(tag);
    check({tag, "_value"}, 32'(value), ev);
    check({tag, "_flags"}, 32'(evt_flags), 32'(f));
    check({tag, "_limit"}, 32'(evt_limit), el);
    check({tag, "_mode"},  32'(mode), em);
    check({tag, "_reads"}, read_cnt - r0, 1);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(evt_valid), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_read",  32'(read), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_flags", 32'(evt_flags), 0);
    check("rst_limit", 32'(evt_limit), 0);
    check("rst_value", 32'(value), 0);
    check("rst_mode",  32'(mode), 0);
    clr = 1'b1;
    @(negedge clk);

    // Single right event with cycle-by-cycle timing.
    rc0 = read_cnt;
    post(3'b010);
    @(negedge clk);
    check("t1_read_hi", 32'(read), 1);
    @(negedge clk);
    check("t1_read_lo", 32'(read), 0);
    check("t1_valid_e1", 32'(evt_valid), 0);
    check("t1_value_e1", 32'(value), 0);
    @(negedge clk);
    check("t1_valid_e2", 32'(evt_valid), 1);
    check("t1_value_e2", 32'(value), 1);
    check("t1_flags", 32'(evt_flags), 3'b010);
    check("t1_limit", 32'(evt_limit), 0);
    @(negedge clk);
    check("t1_valid_e3", 32'(evt_valid), 0);
    check("t1_reads", read_cnt - rc0, 1);

    // Saturate at MIN.
    do_evt("sat_l0", 3'b001, 0, 0, 0);
    do_evt("sat_l1", 3'b001, 0, 1, 0);

    // Climb to MAX, exact landing is not a limit, then saturate.
    for (int i = 1; i <= 9; i++) do_evt("climb", 3'b010, i, 0, 0);
    do_evt("sat_r", 3'b010, 9, 1, 0);

    // Wrap with coarse step.
    do_evt("down8", 3'b001, 8, 0, 0);
    wrap_en = 1'b1;
    do_evt("push", 3'b100, 8, 0, 1);
    do_evt("wrap_r", 3'b010, 1, 1, 1);
    do_evt("wrap_l", 3'b001, 8, 1, 1);

    // All three flags at once.
    do_evt("all3", 3'b111, 8, 0, 0);

    // Backpressure with a second event latched in the decoder meanwhile.
    evt_ready = 1'b0;
    post(3'b001);
    wait_valid("bp1");
    check("bp1_value", 32'(value), 7);
    check("bp1_flags", 32'(evt_flags), 3'b001);
    rc0 = read_cnt;
    post(3'b010);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(evt_valid), 1);
      check("bp_hold_flags", 32'(evt_flags), 3'b001);
      check("bp_hold_value", 32'(value), 7);
      check("bp_hold_read",  32'(read), 0);
    end
    check("bp_no_reads", read_cnt - rc0, 0);
    evt_ready = 1'b1;
    @(negedge clk);
    check("bp_acc_valid", 32'(evt_valid), 0);
    check("bp_acc_read",  32'(read), 0);
    @(negedge clk);
    check("bp_cap_read",  32'(read), 1);
    wait_valid("bp2");
    check("bp2_value", 32'(value), 8);
    check("bp2_flags", 32'(evt_flags), 3'b010);
    check("bp2_limit", 32'(evt_limit), 0);
    @(negedge clk);
    check("bp2_valid_drop", 32'(evt_valid), 0);

    // Asynchronous reset while presenting.
    evt_ready = 1'b0;
    post(3'b100);
    wait_valid("pr");
    check("pr_mode", 32'(mode), 1);
    #2 clr = 1'b0;
    #1;
    check("ar_read",  32'(read), 0);
    check("ar_valid", 32'(evt_valid), 0);
    check("ar_value", 32'(value), 0);
    check("ar_mode",  32'(mode), 0);
    check("ar_flags", 32'(evt_flags), 0);
    check("ar_limit", 32'(evt_limit), 0);
    @(negedge clk);
    clr = 1'b1;
    rc0 = read_cnt;
    repeat (8) @(negedge clk);
    check("post_rst_valid", 32'(evt_valid), 0);
    check("post_rst_reads", read_cnt - rc0, 0);
    check("post_rst_value", 32'(value), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotary_ctrl.md
# rotary_ctrl

Controller that sequences the rotary decoder block. It polls the decoder's latched event flags (rotl_out, rotr_out, push_out) and acknowledges them with a one-cycle read pulse. Each acknowledged event set updates a bounded position value (saturating or wrapping) and a fine/coarse step mode, then is presented downstream on a valid/ready handshake. It sits between the rotary decoder and the application logic (menu/display), so consumers never touch the decoder's read protocol.

## Interface
- WIDTH, 8: width of value.
- MIN, 0: lower bound of value.
- MAX, 255: upper bound of value (MAX > MIN, both fit WIDTH).
- STEP, 1: fine step size.
- COARSE, 10: coarse step size (COARSE ≤ MAX-MIN+1).
- RESET_VAL, 0: value after reset (MIN ≤ RESET_VAL ≤ MAX).

- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- rotl_evt  in  1  decoder's latched left-rotation flag (rotl_out).
- rotr_evt  in  1  decoder's latched right-rotation flag (rotr_out).
- push_evt  in  1  decoder's latched push flag (push_out).
- read  out  1  acknowledge pulse to decoder; decoder clears flags on the edge ending the pulse.
- wrap_en  in  1  1 = wrap at bounds, 0 = saturate.
- evt_ready  in  1  consumer accepts event.
- evt_valid  out  1  event pending.
- evt_flags  out  3  {push, rotr, rotl} captured set.
- evt_limit  out  1  value hit a bound (saturated or wrapped) in this event.
- value  out  WIDTH  current position.
- mode  out  1  0 = fine (STEP), 1 = coarse (COARSE).

## Operation
- FSM states: IDLE, READ, UPDATE, PRESENT.
- IDLE: if any of rotl_evt, rotr_evt, push_evt is high at an edge, capture all three into cap, go to READ, and register read=1. Flags are sampled only in IDLE.
- READ: read=1 for exactly one cycle. On the next edge, read<=0 and go to UPDATE.
- UPDATE: flags are ignored, giving the decoder a cycle to clear. On the edge:
  - Step s = mode ? COARSE : STEP, using mode before any toggle.
  - delta = (cap.rotr ? +s : 0) − (cap.rotl ? s : 0). Both set gives delta 0 and no limit.
  - new = value + delta, evaluated at WIDTH+2 bits signed.
  - Saturate (wrap_en=0): clamp to [MIN, MAX]; evt_limit=1 if clamped.
  - Wrap (wrap_en=1): new > MAX gives MIN + (new−MAX−1); new < MIN gives MAX − (MIN−new−1); evt_limit=1 if wrapped.
  - An exact landing on MIN/MAX is not a limit.
  - Register value, evt_flags<=cap, and evt_limit. If cap.push, mode<=~mode. Set evt_valid<=1, go to PRESENT.
- PRESENT: hold evt_valid, evt_flags and evt_limit stable. At an edge with evt_ready=1, evt_valid<=0 and go to IDLE.
- Events latched by the decoder during PRESENT stay in the decoder and are picked up from IDLE. None are lost.
- wrap_en is sampled in UPDATE only.
- Reset (clr=0, any state, asynchronous): state=IDLE, read=0, evt_valid=0, evt_flags=0, evt_limit=0, value=RESET_VAL, mode=0.

## Timing
- Edge numbering is relative to edge E0, the edge at which IDLE sees a flag.
- read is high during the cycle after E0 and low after E1.
- value, mode and evt_flags update at E2; evt_valid is high from E2.
- If evt_ready is already high, evt_valid is high for one cycle and the FSM is back in IDLE after E3. The earliest next capture is at E4.
- Minimum event period is therefore 4 clocks; back-to-back throughput is 1 event per 4 clocks.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package rotary_pkg holds:
  - the state enum (IDLE, READ, UPDATE, PRESENT);
  - flag bit indices (F_ROTL=0, F_ROTR=1, F_PUSH=2);
  - the 3-bit flag vector typedef.
- Sub-module rotary_step_alu is combinational. Inputs: value, delta sign/magnitude, wrap_en, bounds. Outputs: next value and limit flag. It is parameterised by WIDTH/MIN/MAX.
- FSM, capture register and output registers live in rotary_ctrl.

## Test plan
- Reset: hold clr=0 mid-PRESENT with read=1 pending → read=0, evt_valid=0, value=0, mode=0 immediately. Release → IDLE, no event emitted.
- Single right event, evt_ready=1: pulse rotr_evt → read high exactly 1 cycle, value 0→1, evt_flags=3'b010, evt_valid for 1 cycle, evt_limit=0.
- Saturate: value=1, wrap_en=0, two left events → value 0 (limit 0), then 0 (evt_limit=1). Same at MAX with right events.
- Wrap: MIN=0, MAX=9, push (mode→1, COARSE=10 → use COARSE=3), value=8, wrap_en=1, right → value 1, evt_limit=1. Left from 1 → value 8, evt_limit=1.
- Simultaneous: rotl_evt=rotr_evt=push_evt=1 in the same cycle → one read pulse, value unchanged, evt_flags=3'b111, mode toggles, evt_limit=0.
- Backpressure: evt_ready=0 for 10 cycles while a new rotr_evt latches → evt_valid and evt_flags stable, read stays low. After ready, a second event is captured at the 2nd edge after acceptance and value increments again.
